// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for the single-clock flagged FIFO.
// The FIFO takes the slave side; the surrounding logic takes the master side.
interface sync_fifo_flags_if #(
    parameter int data_size = 8,
    parameter int add_size  = 4
);
    logic [data_size-1:0] data_in;
    logic                 wr_inc;
    logic                 rd_inc;
    logic [data_size-1:0] data_out;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [add_size:0]    count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output data_in, wr_inc, rd_inc,
        input  data_out, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  data_in, wr_inc, rd_inc,
        output data_out, full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and a registered or fall-through read port.
module sync_fifo_flags #(
    parameter int data_size = 8,
    parameter int add_size  = 4,
    parameter int af_level  = 12,
    parameter int ae_level  = 4,
    parameter int fwft      = 0
) (
    input logic              clk,
    input logic              rst_n,
    sync_fifo_flags_if.slave bus
);
    localparam int DEPTH = 1 << add_size;
    localparam logic [add_size:0] FULL_C = (add_size+1)'(DEPTH);
    localparam logic [add_size:0] AF_C   = (add_size+1)'(af_level);
    localparam logic [add_size:0] AE_C   = (add_size+1)'(ae_level);

    logic [data_size-1:0] mem [DEPTH];
    logic [add_size-1:0]  wr_ptr;
    logic [add_size-1:0]  rd_ptr;
    logic [add_size:0]    cnt;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 ovf_q;
    logic                 unf_q;

    // Flags come from the count register alone, never from the requests.
    assign bus.full         = (cnt == FULL_C);
    assign bus.empty        = (cnt == '0);
    assign bus.almost_full  = (cnt >= AF_C);
    assign bus.almost_empty = (cnt <= AE_C);
    assign bus.count        = cnt;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

    assign wr_ok = bus.wr_inc && !bus.full;
    assign rd_ok = bus.rd_inc && !bus.empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            ovf_q <= bus.wr_inc && bus.full;
            unf_q <= bus.rd_inc && bus.empty;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    if (fwft != 0) begin : g_fwft
        assign bus.data_out = bus.empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
        logic [data_size-1:0] dout_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else if (rd_ok) begin
                dout_q <= mem[rd_ptr];
            end
        end

        assign bus.data_out = dout_q;
    end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a registered-read and a fall-through instance
// share one stimulus stream and are checked against a queue model.
module tb_sync_fifo_flags;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.data_size(8), .add_size(4)) ia ();
    sync_fifo_flags_if #(.data_size(8), .add_size(4)) ib ();

    sync_fifo_flags #(.fwft(0)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    sync_fifo_flags #(.fwft(1)) u_ft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] q [$];
    logic [7:0] m_dout0;
    bit         m_ov;
    bit         m_un;

    typedef struct {
        bit         w;
        bit         r;
        logic [7:0] d;
        int         cnt;
        bit         fl;
        bit         em;
        bit         af;
        bit         ae;
        bit         ov;
        bit         un;
        logic [7:0] dout;
    } vec_t;

    vec_t tv [34];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit w, input bit r, input logic [7:0] d);
        ia.wr_inc  = w;
        ia.rd_inc  = r;
        ia.data_in = d;
        ib.wr_inc  = w;
        ib.rd_inc  = r;
        ib.data_in = d;
    endtask

    task automatic check_all();
        int n;
        logic [7:0] ft;
        n  = q.size();
        ft = (n != 0) ? q[0] : 8'h00;
        check("reg count", int'(ia.count), n);
        check("reg full", int'(ia.full), int'(n == 16));
        check("reg empty", int'(ia.empty), int'(n == 0));
        check("reg almost_full", int'(ia.almost_full), int'(n >= 12));
        check("reg almost_empty", int'(ia.almost_empty), int'(n <= 4));
        check("reg overflow", int'(ia.overflow), int'(m_ov));
        check("reg underflow", int'(ia.underflow), int'(m_un));
        check("reg data_out", int'(ia.data_out), int'(m_dout0));
        check("ft count", int'(ib.count), n);
        check("ft full", int'(ib.full), int'(n == 16));
        check("ft empty", int'(ib.empty), int'(n == 0));
        check("ft almost_full", int'(ib.almost_full), int'(n >= 12));
        check("ft almost_empty", int'(ib.almost_empty), int'(n <= 4));
        check("ft overflow", int'(ib.overflow), int'(m_ov));
        check("ft underflow", int'(ib.underflow), int'(m_un));
        check("ft data_out", int'(ib.data_out), int'(ft));
    endtask

    task automatic step(input bit w, input bit r, input logic [7:0] d);
        int n;
        drive(w, r, d);
        @(posedge clk);
        n    = q.size();
        m_ov = w && (n == 16);
        m_un = r && (n == 0);
        if (r && n != 0) begin
            m_dout0 = q.pop_front();
        end
        if (w && n != 16) begin
            q.push_back(d);
        end
        #1;
        check_all();
    endtask

    task automatic model_clear();
        q.delete();
        m_dout0 = 8'h00;
        m_ov    = 1'b0;
        m_un    = 1'b0;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        int pw;
        int pr;

        for (int i = 0; i < 17; i++) begin
            c = (i < 16) ? i + 1 : 16;
            tv[i] = '{1'b1, 1'b0, (i < 16) ? 8'(i) : 8'hAA, c,
                      c == 16, 1'b0, c >= 12, c <= 4, i == 16, 1'b0, 8'h00};
        end
        for (int j = 0; j < 17; j++) begin
            c = (j < 16) ? 15 - j : 0;
            tv[17+j] = '{1'b0, 1'b1, 8'h00, c, 1'b0, c == 0, c >= 12,
                         c <= 4, 1'b0, j == 16, (j < 16) ? 8'(j) : 8'h0F};
        end

        drive(1'b0, 1'b0, 8'h00);
        model_clear();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill past full, then drain past empty.
        foreach (tv[k]) begin
            step(tv[k].w, tv[k].r, tv[k].d);
            check("tbl count", int'(ia.count), tv[k].cnt);
            check("tbl full", int'(ia.full), int'(tv[k].fl));
            check("tbl empty", int'(ia.empty), int'(tv[k].em));
            check("tbl almost_full", int'(ia.almost_full), int'(tv[k].af));
            check("tbl almost_empty", int'(ia.almost_empty), int'(tv[k].ae));
            check("tbl overflow", int'(ia.overflow), int'(tv[k].ov));
            check("tbl underflow", int'(ia.underflow), int'(tv[k].un));
            check("tbl data_out", int'(ia.data_out), int'(tv[k].dout));
        end

        // Wrap-around: three rounds of 10 in, 10 out.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(r * 10 + i));
            for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
        end
        check("wrap count", int'(ia.count), 0);
        check("wrap last", int'(ia.data_out), 29);

        // Simultaneous requests at empty, mid-level and full.
        do_reset();
        step(1'b1, 1'b1, 8'h11);
        check("simul empty count", int'(ia.count), 1);
        check("simul empty underflow", int'(ia.underflow), 1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(8'h40 + i));
        check("simul mid count", int'(ia.count), 8);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
        step(1'b1, 1'b1, 8'hEE);
        check("simul full count", int'(ia.count), 15);
        check("simul full overflow", int'(ia.overflow), 1);
        while (q.size() != 0) step(1'b0, 1'b1, 8'h00);

        // Fall-through: word visible without any read.
        do_reset();
        step(1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b0, 8'h00);
        check("fwft show", int'(ib.data_out), 8'h5A);
        step(1'b0, 1'b1, 8'h00);
        check("fwft popped", int'(ib.data_out), 0);
        check("fwft empty", int'(ib.empty), 1);

        // Asynchronous reset mid-operation at count 9.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'hC9);
        drive(1'b0, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b1, 8'h00);
        check("post reset trip", int'(ia.data_out), 8'h3C);

        // Random traffic with shifting write/read bias.
        do_reset();
        for (int ph = 0; ph < 8; ph++) begin
            pw = (ph % 2 == 0) ? 80 : 25;
            pr = (ph % 2 == 0) ? 25 : 80;
            if (ph >= 6) begin
                pw = 50;
                pr = 50;
            end
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                     8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
